srp_arr_bank: RTL and testbench

//  Parametrised synthesized-array bank: one single-port RAM shared by NCH kernel channels

---
 rtl/srp_arr_bank.sv | 210 +++++++++++++++++++++
 tb/tb_srp_arr_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srp_arr_bank.sv
// -----------------------------------------------------------------------------
// srp_arr_bank
//   One single-port synthesized array shared by NCH kernel channels and a
//   host control port. Access priority is busy > host (controlArr) > kernel.
//   Kernel channels are served round-robin, one access per cycle, and reads
//   complete one cycle after the grant.
//
//   Optional feature macro: ARR_INIT_CLEAR_EN
//     defined   : after reset the array is swept to zero, one element per
//                 cycle, with busy high for DEPTH cycles.
//     undefined : no sweep logic; busy is tied low.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   controlArr          host owns the array while high
//   controlArrWEnable   host write strobe (otherwise host read)
//   controlArrAddr      host address
//   controlArrWData     host write data
//   controlArrRData     host read data, one cycle after the host read
//   k_req / k_we        per-channel request level and write(1)/read(0)
//   k_addr / k_wdata    per-channel address/data, channel i at [i*W +: W]
//   k_gnt               one-hot combinational grant
//   k_rvalid            one-hot read-data-valid, one cycle after read grant
//   k_rdata             shared kernel read data, qualified by k_rvalid
//   busy                array unavailable (init clear in progress)
// -----------------------------------------------------------------------------
module srp_arr_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int NCH    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  controlArr,
    input  logic                  controlArrWEnable,
    input  logic [ADDR_W-1:0]     controlArrAddr,
    input  logic [DATA_W-1:0]     controlArrWData,
    output logic [DATA_W-1:0]     controlArrRData,
    input  logic [NCH-1:0]        k_req,
    input  logic [NCH-1:0]        k_we,
    input  logic [NCH*ADDR_W-1:0] k_addr,
    input  logic [NCH*DATA_W-1:0] k_wdata,
    output logic [NCH-1:0]        k_gnt,
    output logic [NCH-1:0]        k_rvalid,
    output logic [DATA_W-1:0]     k_rdata,
    output logic                  busy
);

    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    // Extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] LP_LAST = PTR_W'(NCH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0]  r_ptr;
    logic [NCH-1:0]    r_rvalid;
    logic [DATA_W-1:0] r_kdata;
    logic [DATA_W-1:0] r_hdata;

    logic              w_busy;
    logic [ADDR_W-1:0] w_clr_addr;

    logic              w_kern_en;
    logic              w_found;
    logic [PTR_W-1:0]  w_sel;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W:0]    w_sum;
    logic [NCH-1:0]    w_gnt;
    logic [PTR_W-1:0]  w_ptr_nxt;

    logic              w_host;
    logic              w_kacc;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rdval;

    // ------------------------------------------------------------------
    // Optional init-clear sweep
    // ------------------------------------------------------------------
`ifdef ARR_INIT_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_READY} sweep_e;

    sweep_e            r_state;
    sweep_e            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt    = ST_READY;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_busy     = (r_state == ST_CLEAR);
    assign w_clr_addr = r_clr_addr;
`else
    assign w_busy     = 1'b0;
    assign w_clr_addr = '0;
`endif

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan upward from r_ptr, wrapping at NCH.
    // ------------------------------------------------------------------
    always_comb begin
        w_kern_en = !w_busy && !controlArr;
        w_found   = 1'b0;
        w_sel     = '0;
        w_idx     = '0;
        w_sum     = '0;
        w_gnt     = '0;
        for (int unsigned off = 0; off < NCH; off++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(off);
            if (w_sum >= (PTR_W+1)'(NCH))
                w_sum = w_sum - (PTR_W+1)'(NCH);
            w_idx = w_sum[PTR_W-1:0];
            if (w_kern_en && !w_found && k_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        if (w_found)
            w_gnt[w_sel] = 1'b1;
        w_ptr_nxt = (w_sel == LP_LAST) ? '0 : w_sel + 1'b1;
    end

    // ------------------------------------------------------------------
    // Single array port mux
    // ------------------------------------------------------------------
    always_comb begin
        w_host  = 1'b0;
        w_kacc  = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (w_busy) begin
            w_we   = 1'b1;
            w_addr = w_clr_addr;
        end else if (controlArr) begin
            w_host  = 1'b1;
            w_we    = controlArrWEnable;
            w_addr  = controlArrAddr;
            w_wdata = controlArrWData;
        end else if (w_found) begin
            w_kacc  = 1'b1;
            w_we    = k_we[w_sel];
            w_addr  = k_addr[w_sel*ADDR_W +: ADDR_W];
            w_wdata = k_wdata[w_sel*DATA_W +: DATA_W];
        end
    end

    assign w_in_range = ({1'b0, w_addr} < LP_DEPTH);
    assign w_rdval    = w_in_range ? r_mem[w_addr] : '0;

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_we && w_in_range)
            r_mem[w_addr] <= w_wdata;
    end

    // ------------------------------------------------------------------
    // Registered outputs and arbiter pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_rvalid <= '0;
            r_kdata  <= '0;
            r_hdata  <= '0;
        end else begin
            if (w_found)
                r_ptr <= w_ptr_nxt;
            r_rvalid <= (w_kacc && !w_we) ? w_gnt : '0;
            if (w_kacc && !w_we)
                r_kdata <= w_rdval;
            // Host read data is zero unless the previous cycle was a host read.
            r_hdata <= (w_host && !w_we) ? w_rdval : '0;
        end
    end

    assign k_gnt           = w_gnt;
    assign k_rvalid        = r_rvalid;
    assign k_rdata         = r_kdata;
    assign controlArrRData = r_hdata;
    assign busy            = w_busy;

endmodule

// File: tb/tb_srp_arr_bank.sv
module tb_srp_arr_bank;

    localparam int DW  = 8;
    localparam int DEP = 12;
    localparam int AW  = 4;
    localparam int NC  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          controlArr = 1'b0;
    logic          controlArrWEnable = 1'b0;
    logic [AW-1:0] controlArrAddr = '0;
    logic [DW-1:0] controlArrWData = '0;
    logic [DW-1:0] controlArrRData;
    logic [NC-1:0] k_req = '0;
    logic [NC-1:0] k_we = '0;
    logic [AW-1:0] ka0 = '0;
    logic [AW-1:0] ka1 = '0;
    logic [DW-1:0] kd0 = '0;
    logic [DW-1:0] kd1 = '0;
    logic [NC*AW-1:0] k_addr;
    logic [NC*DW-1:0] k_wdata;
    logic [NC-1:0] k_gnt;
    logic [NC-1:0] k_rvalid;
    logic [DW-1:0] k_rdata;
    logic          busy;

    assign k_addr  = {ka1, ka0};
    assign k_wdata = {kd1, kd0};

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] mdl [DEP];

    always #5 clk = ~clk;

    srp_arr_bank #(
        .DATA_W(DW),
        .DEPTH (DEP),
        .NCH   (NC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .controlArr       (controlArr),
        .controlArrWEnable(controlArrWEnable),
        .controlArrAddr   (controlArrAddr),
        .controlArrWData  (controlArrWData),
        .controlArrRData  (controlArrRData),
        .k_req            (k_req),
        .k_we             (k_we),
        .k_addr           (k_addr),
        .k_wdata          (k_wdata),
        .k_gnt            (k_gnt),
        .k_rvalid         (k_rvalid),
        .k_rdata          (k_rdata),
        .busy             (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        controlArr        = 1'b1;
        controlArrWEnable = 1'b1;
        controlArrAddr    = a;
        controlArrWData   = d;
        tick();
        controlArrWEnable = 1'b0;
    endtask

    task automatic host_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        controlArr        = 1'b1;
        controlArrWEnable = 1'b0;
        controlArrAddr    = a;
        tick();
        check(tag, 32'(controlArrRData), 32'(exp));
    endtask

    initial begin
        int cnt;
        #3;
        check("rst_gnt",    32'(k_gnt), 32'h0);
        check("rst_rvalid", 32'(k_rvalid), 32'h0);
        check("rst_rdata",  32'(k_rdata), 32'h0);
        check("rst_hdata",  32'(controlArrRData), 32'h0);
`ifdef ARR_INIT_CLEAR_EN
        check("rst_busy",   32'(busy), 32'h1);
`else
        check("rst_busy",   32'(busy), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

`ifdef ARR_INIT_CLEAR_EN
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
        check("sweep_len", 32'(cnt), 32'(DEP));
        // Restart mid-sweep
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        repeat (5) tick();
        check("sweep_mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
        check("sweep_restart_len", 32'(cnt), 32'(DEP));
        host_rd(4'd0,  8'h00, "clr_rd0");
        host_rd(4'd5,  8'h00, "clr_rd5");
        host_rd(4'd11, 8'h00, "clr_rd11");
        controlArr = 1'b0;
`else
        tick();
        check("busy_idle", 32'(busy), 32'h0);
`endif

        // Host write then read
        host_wr(4'd3, 8'h5A);
        host_rd(4'd3, 8'h5A, "host_rw");

        // Fill with known pattern, then an out-of-range host write
        for (int a = 0; a < DEP; a++) begin
            mdl[a] = 8'h20 + 8'(a);
            host_wr(AW'(a), mdl[a]);
        end
        host_wr(4'd14, 8'hEE);
        controlArr = 1'b0;
        tick();
        check("host_rdata_zero", 32'(controlArrRData), 32'h0);

        // Both channels read every cycle: grants alternate
        ka0 = 4'd2; ka1 = 4'd5; k_we = 2'b00; k_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_gnt%0d", i), 32'(k_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check($sformatf("rr_rvalid%0d", i), 32'(k_rvalid), (i % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr_rdata%0d", i), 32'(k_rdata),
                  (i % 2 == 0) ? 32'(mdl[2]) : 32'(mdl[5]));
        end
        k_req = 2'b00;

        // Ch0 write then read same address on the next cycle
        k_req = 2'b01; k_we = 2'b01; ka0 = 4'd7; kd0 = 8'h11;
        #1;
        check("raw_wr_gnt", 32'(k_gnt), 32'h1);
        tick();
        mdl[7] = 8'h11;
        check("raw_wr_norv", 32'(k_rvalid), 32'h0);
        k_we = 2'b00;
        #1;
        check("raw_rd_gnt", 32'(k_gnt), 32'h1);
        tick();
        check("raw_rvalid", 32'(k_rvalid), 32'h1);
        check("raw_rdata",  32'(k_rdata), 32'h11);
        k_req = 2'b00;
        tick();
        check("rv_pulse", 32'(k_rvalid), 32'h0);
        check("rdata_hold", 32'(k_rdata), 32'h11);

        // Host blocks kernels; ptr is at 1 after the last ch0 grant
        ka0 = 4'd4; ka1 = 4'd9; k_we = 2'b00; k_req = 2'b11;
        controlArr = 1'b1; controlArrWEnable = 1'b0; controlArrAddr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("blk_gnt%0d", i), 32'(k_gnt), 32'h0);
            tick();
            check($sformatf("blk_rv%0d", i), 32'(k_rvalid), 32'h0);
            check($sformatf("blk_hd%0d", i), 32'(controlArrRData), 32'(mdl[0]));
        end
        controlArr = 1'b0;
        #1;
        check("resume_gnt", 32'(k_gnt), 32'h2);
        tick();
        check("resume_rv", 32'(k_rvalid), 32'h2);
        check("resume_rd", 32'(k_rdata), 32'(mdl[9]));
        check("resume_hd0", 32'(controlArrRData), 32'h0);
        k_req = 2'b00;

        // Host takes over while a kernel read is in flight
        k_req = 2'b01; ka0 = 4'd4;
        #1;
        check("fl_gnt", 32'(k_gnt), 32'h1);
        tick();
        controlArr = 1'b1; controlArrWEnable = 1'b1; controlArrAddr = 4'd6; controlArrWData = 8'h66;
        #1;
        check("fl_rv", 32'(k_rvalid), 32'h1);
        check("fl_rd", 32'(k_rdata), 32'(mdl[4]));
        check("fl_gnt_blk", 32'(k_gnt), 32'h0);
        tick();
        mdl[6] = 8'h66;
        check("fl_rv_end", 32'(k_rvalid), 32'h0);
        controlArrWEnable = 1'b0;
        tick();
        check("fl_host_rd", 32'(controlArrRData), 32'h66);
        controlArr = 1'b0;
        k_req = 2'b00;

        // Out-of-range kernel write/read on ch1 (back-to-back grants)
        k_req = 2'b10; k_we = 2'b10; ka1 = 4'd13; kd1 = 8'hFF;
        #1;
        check("oor_wr_gnt", 32'(k_gnt), 32'h2);
        tick();
        k_we = 2'b00;
        #1;
        check("oor_rd_gnt", 32'(k_gnt), 32'h2);
        tick();
        check("oor_rv", 32'(k_rvalid), 32'h2);
        check("oor_rd", 32'(k_rdata), 32'h0);
        k_req = 2'b00;
        host_rd(4'd13, 8'h00, "oor_host_rd");
        for (int a = 0; a < DEP; a++)
            host_rd(AW'(a), mdl[a], $sformatf("mem%0d", a));
        controlArr = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
